// File: rtl/temporal_pkg.sv
// Shared types and width helpers for the temporal less-than array and its lanes.
package temporal_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRE  = 2'd1,
        INHIB = 2'd2,
        DONE  = 2'd3
    } lane_state_t;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

    localparam int GAMMA_DEFAULT = 16;
    localparam int PULSE_DEFAULT = 8;

    function automatic int phase_w(input int gamma_cycles);
        return $clog2(gamma_cycles);
    endfunction

    function automatic int cnt_w(input int pulse_cycles);
        return $clog2(pulse_cycles + 1);
    endfunction

endpackage

// File: rtl/temporal_lt_lane.sv
// One less-than lane: edge detection on a/b, a four-state race FSM and the
// q pulse counter. State is exported for observation.
module temporal_lt_lane
    import temporal_pkg::*;
#(
    parameter int PULSE_WIDTH = PULSE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        mode_r,
    input  logic        a,
    input  logic        b,
    output logic        q,
    output logic        decided,
    output lane_state_t state
);
    localparam int CNT_W = cnt_w(PULSE_WIDTH);

    logic a_s1_q, a_s0_q, b_s1_q, b_s0_q;
    logic a_evt, b_evt;
    lane_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic q_q, q_d, dec_q, dec_d;

    assign a_evt = (mode_r == EDGE_FALL) ? (~a_s1_q & a_s0_q) : (a_s1_q & ~a_s0_q);
    assign b_evt = (mode_r == EDGE_FALL) ? (~b_s1_q & b_s0_q) : (b_s1_q & ~b_s0_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_s1_q  <= 1'b0;
            a_s0_q  <= 1'b0;
            b_s1_q  <= 1'b0;
            b_s0_q  <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            dec_q   <= 1'b0;
        end else begin
            a_s1_q  <= a;
            a_s0_q  <= a_s1_q;
            b_s1_q  <= b;
            b_s0_q  <= b_s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            dec_q   <= dec_d;
        end
    end

    // A b-event on the same cycle as an a-event inhibits: ties lose.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (b_evt) begin
                        state_d = INHIB;
                    end else if (a_evt) begin
                        state_d = FIRE;
                        cnt_d   = CNT_W'(PULSE_WIDTH);
                    end
                end
                FIRE: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        q_d   = (state_q == FIRE) & ~clear;
        dec_d = (state_d != IDLE);
    end

    assign q       = q_q;
    assign decided = dec_q;
    assign state   = state_q;

endmodule

// File: rtl/temporal_lt_array.sv
// Multi-lane temporal less-than array: owns the gamma-cycle timebase and fans a
// shared clear and edge mode out to independent comparison lanes.
module temporal_lt_array
    import temporal_pkg::*;
#(
    parameter int N_CH              = 4,
    parameter int GAMMA_CYCLE_WIDTH = GAMMA_DEFAULT,
    parameter int PULSE_WIDTH       = PULSE_DEFAULT,
    parameter int PHASE_W           = phase_w(GAMMA_CYCLE_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 mode,
    input  logic [N_CH-1:0]      a,
    input  logic [N_CH-1:0]      b,
    output logic [N_CH-1:0]      q,
    output logic [N_CH-1:0]      decided,
    output logic                 gamma_start,
    output logic [PHASE_W-1:0]   phase,
    output logic [2*N_CH-1:0]    lane_state
);
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(GAMMA_CYCLE_WIDTH - 1);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic run_q, gs_q, gs_d, mode_r_q, lane_clear;

    // run_q distinguishes the first enabled cycle, which must present phase 0
    // with gamma_start, from a running counter that is merely passing phase 0.
    always_comb begin
        phase_d = '0;
        gs_d    = 1'b0;
        if (en) begin
            if (run_q && (phase_q != LAST_PHASE)) begin
                phase_d = phase_q + PHASE_W'(1);
            end
            gs_d = (phase_d == '0);
        end
    end

    assign lane_clear = ~en | ~run_q | (phase_q == LAST_PHASE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            phase_q  <= '0;
            gs_q     <= 1'b0;
            mode_r_q <= EDGE_RISE;
        end else begin
            run_q   <= en;
            phase_q <= phase_d;
            gs_q    <= gs_d;
            if (phase_q == '0) begin
                mode_r_q <= mode;
            end
        end
    end

    assign phase       = phase_q;
    assign gamma_start = gs_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        lane_state_t st;

        temporal_lt_lane #(
            .PULSE_WIDTH(PULSE_WIDTH)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .clear  (lane_clear),
            .mode_r (mode_r_q),
            .a      (a[i]),
            .b      (b[i]),
            .q      (q[i]),
            .decided(decided[i]),
            .state  (st)
        );

        assign lane_state[2*i +: 2] = st;
    end

endmodule

// File: tb/tb_temporal_lt_array.sv
// Bench for temporal_lt_array: stimulus segments are scored against a
// gamma-window reference model through an expected-value queue.
module tb_temporal_lt_array;
    import temporal_pkg::*;

    localparam int N_CH = 4;
    localparam int G    = 16;
    localparam int PW   = 8;
    localparam int PHW  = $clog2(G);
    localparam int MAXN = 512;
    localparam int W    = 2 * N_CH + PHW + 1;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic            en = 1'b0;
    logic            mode = 1'b0;
    logic [N_CH-1:0] a = '0;
    logic [N_CH-1:0] b = '0;
    logic [N_CH-1:0] q, decided;
    logic            gamma_start;
    logic [PHW-1:0]  phase;
    logic [2*N_CH-1:0] lane_state;

    temporal_lt_array #(
        .N_CH(N_CH), .GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b),
        .q(q), .decided(decided), .gamma_start(gamma_start), .phase(phase),
        .lane_state(lane_state)
    );

    // stimulus and reference arrays, index t = output after clock edge t
    logic            en_s   [MAXN];
    logic            mode_s [MAXN];
    logic [N_CH-1:0] a_s    [MAXN];
    logic [N_CH-1:0] b_s    [MAXN];
    logic [PHW-1:0]  ph_e   [MAXN];
    logic            gs_e   [MAXN];
    logic            mr_e   [MAXN];
    logic [N_CH-1:0] q_e    [MAXN];
    logic [N_CH-1:0] d_e    [MAXN];

    logic [W-1:0] exp_q[$];
    int           exp_t[$];
    int           n_checks = 0;
    int           n_fails  = 0;
    int           seg_id   = 0;

    function automatic logic edge_ev(input logic cur, input logic prev, input logic falling);
        return falling ? (prev && !cur) : (cur && !prev);
    endfunction

    // Reference model: per gamma window find each lane's first a and b events
    // and derive the decided span and the (truncated) q pulse from them.
    task automatic compute(input int n);
        int started, e, ta, tb, last;
        started = 0;
        ph_e[0] = '0; gs_e[0] = 1'b0; mr_e[0] = 1'b0;
        q_e[0] = '0; d_e[0] = '0;
        for (int t = 1; t <= n; t++) begin
            if (!en_s[t]) begin
                ph_e[t] = '0; gs_e[t] = 1'b0; started = 0;
            end else if (started == 0) begin
                ph_e[t] = '0; gs_e[t] = 1'b1; started = 1;
            end else begin
                ph_e[t] = PHW'((int'(ph_e[t-1]) + 1) % G);
                gs_e[t] = (ph_e[t] == '0);
            end
            mr_e[t] = (ph_e[t-1] == '0) ? mode_s[t] : mr_e[t-1];
            q_e[t] = '0;
            d_e[t] = '0;
        end
        for (int s = 1; s <= n; s++) begin
            if (gs_e[s]) begin
                e = s;
                while (e < n && ph_e[e+1] != '0) e++;
                for (int l = 0; l < N_CH; l++) begin
                    ta = -1; tb = -1;
                    for (int t = s; t < e; t++) begin
                        if (ta < 0 && edge_ev(a_s[t][l], a_s[t-1][l], mr_e[t])) ta = t;
                        if (tb < 0 && edge_ev(b_s[t][l], b_s[t-1][l], mr_e[t])) tb = t;
                    end
                    if (ta >= 0 && (tb < 0 || tb > ta)) begin
                        for (int c = ta + 1; c <= e; c++) d_e[c][l] = 1'b1;
                        last = (ta + 1 + PW > e) ? e : ta + 1 + PW;
                        for (int c = ta + 2; c <= last; c++) q_e[c][l] = 1'b1;
                    end else if (tb >= 0) begin
                        for (int c = tb + 1; c <= e; c++) d_e[c][l] = 1'b1;
                    end
                end
            end
        end
    endtask

    // driver tasks
    task automatic run_segment(input int n);
        seg_id++;
        compute(n);
        for (int t = 1; t <= n; t++) begin
            @(negedge clk);
            en   = en_s[t];
            mode = mode_s[t];
            a    = a_s[t];
            b    = b_s[t];
            exp_q.push_back({gs_e[t], ph_e[t], d_e[t], q_e[t]});
            exp_t.push_back(t);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        en = 1'b0; mode = 1'b0; a = '0; b = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_stim();
        for (int t = 0; t < MAXN; t++) begin
            en_s[t] = 1'b0; mode_s[t] = 1'b0; a_s[t] = '0; b_s[t] = '0;
        end
    endtask

    task automatic gen_random(input int n);
        clear_stim();
        for (int t = 1; t <= n; t++) begin
            if (t < 3) en_s[t] = 1'b1;
            else if (en_s[t-1]) en_s[t] = ($urandom_range(0, 59) != 0);
            else en_s[t] = ($urandom_range(0, 3) == 0);
            mode_s[t] = ($urandom_range(0, 29) == 0) ? ~mode_s[t-1] : mode_s[t-1];
            for (int l = 0; l < N_CH; l++) begin
                a_s[t][l] = ($urandom_range(0, 7) == 0) ? ~a_s[t-1][l] : a_s[t-1][l];
                b_s[t][l] = ($urandom_range(0, 7) == 0) ? ~b_s[t-1][l] : b_s[t-1][l];
            end
        end
    endtask

    // scoreboard monitor: async reset checks and per-cycle queue comparisons
    always @(posedge clk or negedge rst_n) begin
        logic [W-1:0] obs, expv;
        int t;
        #1;
        if (!rst_n) begin
            obs = {gamma_start, phase, decided, q};
            n_checks++;
            if (obs !== '0) begin
                n_fails++;
                $display("FAIL reset_state: gs=%b phase=%0d decided=%b q=%b, want all zero",
                         gamma_start, phase, decided, q);
            end
        end else if (exp_q.size() > 0) begin
            obs  = {gamma_start, phase, decided, q};
            expv = exp_q.pop_front();
            t    = exp_t.pop_front();
            n_checks++;
            if (obs !== expv) begin
                n_fails++;
                $display("FAIL seg%0d_cycle%0d: got gs=%b phase=%0d decided=%b q=%b (lanes=%h), want gs=%b phase=%0d decided=%b q=%b",
                         seg_id, t, gamma_start, phase, decided, q, lane_state,
                         expv[W-1], expv[W-2 -: PHW], expv[2*N_CH-1 -: N_CH], expv[N_CH-1:0]);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed: win, loss, tie and wrap truncation, then a mid-cycle mode change.
        clear_stim();
        for (int t = 1; t <= 48; t++) begin
            en_s[t]   = 1'b1;
            mode_s[t] = (t >= 20);
            a_s[t][0] = (t >= 4 && t < 37);
            b_s[t][0] = (t >= 8 && t < 40);
            b_s[t][1] = (t >= 3);
            a_s[t][1] = (t >= 6);
            a_s[t][2] = (t >= 5 && t < 19) || (t >= 38);
            b_s[t][2] = a_s[t][2];
            a_s[t][3] = (t >= 13);
            b_s[t][3] = 1'b0;
        end
        run_segment(48);
        do_reset();

        // Directed: reset lands in the middle of a q[0] pulse.
        clear_stim();
        for (int t = 1; t <= 8; t++) begin
            en_s[t]   = 1'b1;
            a_s[t][0] = (t >= 3);
        end
        run_segment(8);
        do_reset();

        for (int k = 0; k < 4; k++) begin
            gen_random(240);
            run_segment(240);
            do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
